// File: rtl/dropout_pkg.sv
// Shared constants and helpers for the dropout array: LFSR taps, lane seeding
// and the drop-counter width.
package dropout_pkg;

  localparam int          DROP_CNT_W     = 16;
  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LANE_SEED_MULT = 16'h9E37;

  // Decorrelate lanes from one base seed; an all-zero LFSR would lock up.
  function automatic logic [15:0] lane_seed(input logic [15:0] base, input int unsigned idx);
    logic [31:0] prod;
    logic [15:0] s;
    prod = idx * {16'h0000, LANE_SEED_MULT};
    s    = base ^ prod[15:0];
    if (s == 16'h0000) s = 16'h0001;
    return s;
  endfunction

endpackage

// File: rtl/dropout_array_if.sv
// Stream bus of the dropout array: input beat, masked output beat and lane mask.
interface dropout_array_if #(
  parameter int LANES  = 8,
  parameter int DATA_W = 1
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   datain;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   dataout;
  logic [LANES-1:0]          mask;

  modport master (
    output in_valid, datain, out_ready,
    input  in_ready, out_valid, dataout, mask
  );

  modport slave (
    input  in_valid, datain, out_ready,
    output in_ready, out_valid, dataout, mask
  );
endinterface

// File: rtl/dropout_lfsr.sv
// One Fibonacci LFSR lane: shift left, parity of tapped bits enters bit 0.
module dropout_lfsr
  import dropout_pkg::*;
#(
  parameter int           W       = 16,
  parameter logic [W-1:0] RST_VAL = 16'h0001
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] state
);

  logic fb;
  assign fb = ^(state & LFSR_TAPS[W-1:0]);

  always_ff @(posedge clk) begin
    if (reset)     state <= RST_VAL;
    else if (load) state <= load_val;
    else if (step) state <= {state[W-2:0], fb};
  end

endmodule

// File: rtl/dropout_array.sv
// Streaming random-dropout engine: per-lane LFSRs zero lanes with probability
// drop_prob/256, registered output with valid/ready and a saturating drop count.
module dropout_array
  import dropout_pkg::*;
#(
  parameter int          LANES  = 8,
  parameter int          DATA_W = 1,
  parameter int          LFSR_W = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [7:0]            drop_prob,
  input  logic                  seed_load,
  input  logic [LFSR_W-1:0]     seed,
  dropout_array_if.slave        bus,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int CNT_W = $clog2(LANES + 1);

  logic [LANES-1:0][LFSR_W-1:0] lfsr_q;
  logic [LANES-1:0]             keep;
  logic [LANES*DATA_W-1:0]      masked;
  logic [LANES*DATA_W-1:0]      dataout_q;
  logic [LANES-1:0]             mask_q;
  logic                         out_valid_q;
  logic                         in_ready;
  logic                         accept;
  logic                         lfsr_load;
  logic                         lfsr_step;
  logic [CNT_W-1:0]             n_drop;
  logic [DROP_CNT_W:0]          cnt_sum;
  logic [DROP_CNT_W-1:0]        cnt_next;

  // in_ready depends on out_ready but never on in_valid
  assign in_ready  = enable && !seed_load && (!out_valid_q || bus.out_ready);
  assign accept    = enable && bus.in_valid && in_ready;
  assign lfsr_load = enable && seed_load;
  assign lfsr_step = accept && mode;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [15:0] RST16 = lane_seed(SEED, i);
    logic [15:0] ld16;
    assign ld16 = lane_seed(seed, i);

    dropout_lfsr #(
      .W       (LFSR_W),
      .RST_VAL (RST16[LFSR_W-1:0])
    ) u_lfsr (
      .clk      (clk),
      .reset    (reset),
      .load     (lfsr_load),
      .load_val (ld16[LFSR_W-1:0]),
      .step     (lfsr_step),
      .state    (lfsr_q[i])
    );

    assign keep[i] = !mode || (lfsr_q[i][7:0] >= drop_prob);
    assign masked[i*DATA_W +: DATA_W] = bus.datain[i*DATA_W +: DATA_W] & {DATA_W{keep[i]}};
  end

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < LANES; i++) n_drop = n_drop + CNT_W'(~keep[i]);
  end

  assign cnt_sum  = {1'b0, drop_count} + (DROP_CNT_W + 1)'(n_drop);
  assign cnt_next = cnt_sum[DROP_CNT_W] ? '1 : cnt_sum[DROP_CNT_W-1:0];

  // A drain and a fresh accept in the same cycle keep out_valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dataout_q   <= '0;
      mask_q      <= '0;
      drop_count  <= '0;
    end else if (enable) begin
      if (accept) begin
        out_valid_q <= 1'b1;
        dataout_q   <= masked;
        mask_q      <= keep;
        if (mode) drop_count <= cnt_next;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.dataout   = dataout_q;
  assign bus.mask      = mask_q;

endmodule

// File: tb/tb_dropout_array.sv
// Directed bench for dropout_array with a cycle-level reference model of the
// LFSRs, output register and drop counter.
module tb_dropout_array;

  localparam int LANES = 8;

  logic        clk = 1'b0;
  logic        reset, enable, mode, seed_load;
  logic [7:0]  drop_prob;
  logic [15:0] seed;
  logic [15:0] drop_count;

  dropout_array_if #(.LANES(LANES), .DATA_W(1)) bus ();

  dropout_array #(.LANES(LANES), .DATA_W(1), .LFSR_W(16), .SEED(16'hACE1)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .drop_prob  (drop_prob),
    .seed_load  (seed_load),
    .seed       (seed),
    .bus        (bus),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int ntest = 0;
  int nfail = 0;

  logic [15:0] m_lf [LANES];
  logic        m_vld;
  logic [7:0]  m_data, m_mask;
  logic [15:0] m_cnt;
  logic [7:0]  rec [1000];

  function automatic logic [15:0] mseed(input logic [15:0] b, input int i);
    logic [31:0] p;
    logic [15:0] s;
    p = i * 32'h0000_9E37;
    s = b ^ p[15:0];
    if (s == 16'h0) s = 16'h0001;
    return s;
  endfunction

  function automatic logic [15:0] mstep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Advance the reference model with the inputs currently applied, then clock.
  task automatic tick();
    logic       rdy, acc;
    logic [7:0] km;
    int         nd;
    logic [16:0] s;
    rdy = enable && !seed_load && (!m_vld || bus.out_ready);
    acc = enable && bus.in_valid && rdy;
    if (reset) begin
      m_vld = 1'b0; m_data = '0; m_mask = '0; m_cnt = '0;
      for (int i = 0; i < LANES; i++) m_lf[i] = mseed(16'hACE1, i);
    end else if (enable) begin
      if (seed_load) for (int i = 0; i < LANES; i++) m_lf[i] = mseed(seed, i);
      if (acc) begin
        nd = 0;
        for (int i = 0; i < LANES; i++) begin
          km[i] = !mode || (m_lf[i][7:0] >= drop_prob);
          if (!km[i]) nd++;
        end
        m_mask = km;
        m_data = bus.datain & km;
        m_vld  = 1'b1;
        if (mode) begin
          s     = {1'b0, m_cnt} + 17'(nd);
          m_cnt = s[16] ? 16'hFFFF : s[15:0];
          for (int i = 0; i < LANES; i++) m_lf[i] = mstep(m_lf[i]);
        end
      end else if (bus.out_ready) begin
        m_vld = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; mode = 1'b1; drop_prob = 8'd0;
    seed_load = 1'b0; seed = 16'h0;
    bus.in_valid = 1'b1; bus.datain = 8'hA5; bus.out_ready = 1'b1;
    tick(); tick();
    ntest++; if (bus.out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    ntest++; if (bus.dataout !== 8'h00) begin nfail++; $display("FAIL reset_dataout got %h want 00", bus.dataout); end
    ntest++; if (bus.mask !== 8'h00) begin nfail++; $display("FAIL reset_mask got %h want 00", bus.mask); end
    ntest++; if (drop_count !== 16'h0) begin nfail++; $display("FAIL reset_drop_count got %h want 0000", drop_count); end
    ntest++; if (dut.g_lane[0].u_lfsr.state !== 16'hACE1) begin nfail++; $display("FAIL reset_lfsr0 got %h want ACE1", dut.g_lane[0].u_lfsr.state); end
    ntest++; if (dut.g_lane[1].u_lfsr.state !== 16'h32D6) begin nfail++; $display("FAIL reset_lfsr1 got %h want 32D6", dut.g_lane[1].u_lfsr.state); end
    reset = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [7:0] din;
    mode = 1'b1; drop_prob = 8'd0; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      din = 8'($urandom);
      bus.datain = din;
      tick();
      ntest++;
      if (bus.out_valid !== 1'b1 || bus.dataout !== din || bus.mask !== 8'hFF || drop_count !== 16'h0) begin
        nfail++;
        $display("FAIL passthrough beat %0d got v=%b d=%h m=%h c=%h want v=1 d=%h m=FF c=0000",
                 k, bus.out_valid, bus.dataout, bus.mask, drop_count, din);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    ntest++; if (bus.out_valid !== 1'b0) begin nfail++; $display("FAIL passthrough_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_bit_exact();
    mode = 1'b1; drop_prob = 8'd128; bus.out_ready = 1'b1;
    seed = 16'h1234; seed_load = 1'b1; bus.in_valid = 1'b1; bus.datain = 8'hFF;
    #1;
    ntest++; if (bus.in_ready !== 1'b0) begin nfail++; $display("FAIL seed_load_in_ready got %b want 0", bus.in_ready); end
    tick();
    seed_load = 1'b0;
    ntest++; if (dut.g_lane[0].u_lfsr.state !== 16'h1234) begin nfail++; $display("FAIL seed_lfsr0 got %h want 1234", dut.g_lane[0].u_lfsr.state); end
    for (int k = 0; k < 1000; k++) begin
      bus.datain = 8'($urandom);
      tick();
      rec[k] = m_mask;
      ntest++;
      if (bus.out_valid !== m_vld || bus.dataout !== m_data || bus.mask !== m_mask || drop_count !== m_cnt) begin
        nfail++;
        $display("FAIL bit_exact beat %0d got d=%h m=%h c=%h want d=%h m=%h c=%h",
                 k, bus.dataout, bus.mask, drop_count, m_data, m_mask, m_cnt);
      end
    end
    bus.in_valid = 1'b0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0; bus.in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      bus.datain = 8'($urandom);
      tick();
      ntest++;
      if (bus.mask !== rec[k] || drop_count !== m_cnt) begin
        nfail++;
        $display("FAIL reseed_repeat beat %0d got m=%h c=%h want m=%h c=%h", k, bus.mask, drop_count, rec[k], m_cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b1; drop_prob = 8'd100;
    for (int k = 0; k < 300; k++) begin
      enable       = !(k >= 150 && k < 155);
      bus.in_valid = ($urandom_range(3) != 0);
      bus.out_ready = 1'($urandom);
      bus.datain   = 8'($urandom);
      #1;
      ntest++;
      if (bus.in_ready !== (enable && !seed_load && (!m_vld || bus.out_ready))) begin
        nfail++; $display("FAIL backpressure_in_ready cycle %0d got %b", k, bus.in_ready);
      end
      tick();
      ntest++;
      if (bus.out_valid !== m_vld || bus.dataout !== m_data || bus.mask !== m_mask || drop_count !== m_cnt) begin
        nfail++;
        $display("FAIL backpressure cycle %0d got v=%b d=%h m=%h c=%h want v=%b d=%h m=%h c=%h",
                 k, bus.out_valid, bus.dataout, bus.mask, drop_count, m_vld, m_data, m_mask, m_cnt);
      end
    end
    enable = 1'b1;
    ntest++; if (dut.g_lane[0].u_lfsr.state !== m_lf[0]) begin nfail++; $display("FAIL backpressure_lfsr0 got %h want %h", dut.g_lane[0].u_lfsr.state, m_lf[0]); end
    ntest++; if (dut.g_lane[7].u_lfsr.state !== m_lf[7]) begin nfail++; $display("FAIL backpressure_lfsr7 got %h want %h", dut.g_lane[7].u_lfsr.state, m_lf[7]); end
  endtask

  task automatic test_bypass();
    logic [15:0] cnt0, lf0;
    logic [7:0]  din;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    mode = 1'b0; drop_prob = 8'd255;
    cnt0 = m_cnt; lf0 = m_lf[0];
    for (int k = 0; k < 50; k++) begin
      din = 8'($urandom);
      bus.datain = din;
      tick();
      ntest++;
      if (bus.mask !== 8'hFF || bus.dataout !== din || drop_count !== cnt0) begin
        nfail++;
        $display("FAIL bypass beat %0d got d=%h m=%h c=%h want d=%h m=FF c=%h", k, bus.dataout, bus.mask, drop_count, din, cnt0);
      end
    end
    ntest++; if (dut.g_lane[0].u_lfsr.state !== lf0) begin nfail++; $display("FAIL bypass_lfsr_frozen got %h want %h", dut.g_lane[0].u_lfsr.state, lf0); end
    mode = 1'b1; drop_prob = 8'd128;
    for (int k = 0; k < 50; k++) begin
      bus.datain = 8'($urandom);
      tick();
      ntest++;
      if (bus.mask !== m_mask || bus.dataout !== m_data || drop_count !== m_cnt) begin
        nfail++;
        $display("FAIL bypass_resume beat %0d got m=%h c=%h want m=%h c=%h", k, bus.mask, drop_count, m_mask, m_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    mode = 1'b1; drop_prob = 8'd255; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    for (int k = 0; k < 9000; k++) begin
      bus.datain = 8'($urandom);
      tick();
      if (k % 500 == 499) begin
        ntest++;
        if (drop_count !== m_cnt || bus.mask !== m_mask) begin
          nfail++;
          $display("FAIL saturation beat %0d got c=%h m=%h want c=%h m=%h", k, drop_count, bus.mask, m_cnt, m_mask);
        end
      end
    end
    ntest++; if (drop_count !== 16'hFFFF) begin nfail++; $display("FAIL saturation_reached got %h want FFFF", drop_count); end
    for (int k = 0; k < 20; k++) tick();
    ntest++; if (drop_count !== 16'hFFFF) begin nfail++; $display("FAIL saturation_hold got %h want FFFF", drop_count); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; mode = 1'b0; drop_prob = '0;
    seed_load = 1'b0; seed = '0;
    bus.in_valid = 1'b0; bus.datain = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_bit_exact();
    test_backpressure();
    test_bypass();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/dropout_array.md
# dropout_array

Parametrised, streaming random-dropout engine: LANES independent lanes of DATA_W bits, each zeroed per beat with programmable probability drop_prob/256, using per-lane LFSRs. It sits between the chip input bus and the output bus in the Tiny Tapeout top level, replacing the fixed single-mode dropout. Over the fixed block it adds:
- valid/ready flow control
- bypass/dropout mode
- run-time seeding
- exported mask
- dropped-lane statistics

## Interface
Parameters:
- LANES, 8, number of lanes
- DATA_W, 1, bits per lane (default bus = 8 bits)
- LFSR_W, 16, per-lane LFSR width (fixed taps defined for 16 only)
- SEED, 16'hACE1, reset seed base

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  global stall when low: in_ready=0, all state frozen
- mode  in  1  0=bypass (mask all ones), 1=dropout
- drop_prob  in  8  drop threshold; lane dropped when its random byte < drop_prob
- seed_load  in  1  reload all LFSRs from seed port
- seed  in  LFSR_W  run-time seed base
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat
- datain  in  LANES*DATA_W  lane i = bits [i*DATA_W +: DATA_W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- dataout  out  LANES*DATA_W  masked data
- mask  out  LANES  1=lane kept, aligned with dataout
- drop_count  out  16  total dropped lanes, saturating

## Operation
- Lane seed: lane i seed = base ^ (i × 16'h9E37), truncated to LFSR_W; a zero result becomes 16'h0001. base = SEED at reset, seed port on seed_load.
- LFSR: Fibonacci, shift left; new bit0 = b15^b13^b12^b10 (x^16+x^14+x^13+x^11+1), period 65535.
- Random byte for lane i = its current LFSR[7:0].
- keep_i = (mode==0) || (rand_i >= drop_prob). drop_prob=0 never drops.
- Output lane = keep_i ? datain lane : 0.
- Accept = enable && in_valid && in_ready. On accept:
  - dataout, mask, out_valid=1 register.
  - In dropout mode, every LFSR advances one step and drop_count += number of zero mask bits, saturating at 16'hFFFF.
  - In bypass mode, LFSRs and drop_count are unchanged.
- seed_load && enable: LFSRs reload; in_ready forced 0 that cycle; drop_count unchanged; output register unaffected.
- out_valid clears when out_ready && !accept in the same cycle (enable high).

## Timing
- Reset (sync, synchronous to clk), applied next edge:
  - out_valid=0, dataout=0, mask=0, drop_count=0
  - LFSRs = lane seeds from SEED
  - Overrides seed_load and accept; mid-beat data is lost.
- in_ready = enable && !seed_load && (!out_valid || out_ready). Combinational from out_ready, no combinational path from in_valid.
- Latency: accepted beat appears on dataout/mask exactly one cycle later.
- Throughput: 1 beat/cycle with out_ready held high.
- Output hold: with out_valid=1 and out_ready=0, dataout/mask/out_valid stay stable and no LFSR advance.
- Simultaneous drain + accept: new beat replaces old, out_valid stays 1.
- Mode and drop_prob are sampled only at accept; changing them mid-stream affects only later beats.
- enable low: everything frozen, including out_valid; out_ready is ignored.

## Structure
- Package dropout_pkg:
  - LFSR tap constant
  - lane-seed multiplier 16'h9E37
  - DROP_CNT_W=16
  - function lane_seed(base, i) with zero fix-up
- Sub-module dropout_lfsr: one LFSR, with ports clk, reset, load, load_val, step, state. Instantiated LANES times in a generate loop.
- Top level contains:
  - keep compare
  - output register
  - popcount/saturating counter
  - handshake

## Test plan
- Reset check: assert reset 2 cycles with in_valid=1 -> out_valid=0, dataout=0, mask=0, drop_count=0. Lane 0 LFSR = 16'hACE1, lane 1 = 16'hACE1^16'h9E37.
- Passthrough: mode=1, drop_prob=0, 100 random beats, out_ready=1 -> dataout==datain delayed 1 cycle, mask=8'hFF, drop_count=0.
- Bit-exact model: mode=1, drop_prob=128, seed_load with seed=16'h1234, 1000 beats -> mask and drop_count match a software LFSR model every beat. Repeat seed_load -> identical mask sequence.
- Backpressure: out_ready toggled randomly, enable dropped 5 cycles mid-stream -> no beat lost or duplicated, held output stable, LFSR advances exactly once per accepted beat.
- Bypass: mode=0, drop_prob=255 -> mask=8'hFF, drop_count frozen. Switching to mode=1 resumes the mask sequence where it left off.
- Saturation: drop_prob=255, mode=1, 9000 beats -> drop_count reaches 16'hFFFF and holds, no wrap.
